mem_align_unit: RTL and testbench

Misaligned-access splitter in the memory stage, directly upstream of the data-cache port. It takes one load/store request per cycle from the EX/MEM pipeline register and drives the data-cache port signals. Aligned requests pass through in the same cycle. Misaligned requests are broken into a sequence of cache accesses the cache itself can serve: two aligned word reads for a load, or byte writes for a store. The pipeline is stalled until the sequence completes.

---
 rtl/mem_align_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_align_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_align_unit.sv
// Misaligned-access splitter between the EX/MEM register and the data-cache port.
// Splitting is built only when MEM_ALIGN_SPLIT_EN is defined; otherwise misaligned requests are flagged.
module mem_align_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_rd,
    input  logic [1:0]        req_width,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              align_stall,
    output logic [DATA_W-1:0] align_ldata,
    output logic              align_misalign,
    output logic              Mem_DcacheEN,
    output logic              Mem_DcacheRd,
    output logic [1:0]        Mem_DcacheWidth,
    output logic              Mem_DcacheSign,
    output logic [ADDR_W-1:0] Mem_DcacheAddr,
    output logic [DATA_W-1:0] EXMem_Rs2Data,
    input  logic [DATA_W-1:0] Dcache_DataRd
);

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_NONE = 2'b11;

    logic req_ok;
    logic misaligned;
    logic in_idle;

    assign req_ok     = req_en && (req_width != W_NONE);
    assign misaligned = ((req_width == W_HALF) && req_addr[0]) ||
                        ((req_width == W_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MEM_ALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;

    state_t            state;
    logic [31:0]       lo_reg;
    logic [1:0]        cnt;
    logic [1:0]        st_last;
    logic [ADDR_W-1:0] base;
    logic [63:0]       ld_pair;
    logic [DATA_W-1:0] ld_ext;

    assign in_idle = (state == IDLE);
    assign st_last = (req_width == W_HALF) ? 2'd1 : 2'd3;
    assign base    = {req_addr[ADDR_W-1:2], 2'b00};

    // The high word arrives in LD_HI; shifting the pair right by the byte offset lands the request at bit 0.
    assign ld_pair = {Dcache_DataRd, lo_reg} >> {req_addr[1:0], 3'b000};

    always_comb begin
        ld_ext = ld_pair[31:0];
        case (req_width)
            W_BYTE:  ld_ext = {{24{req_sign & ld_pair[7]}}, ld_pair[7:0]};
            W_HALF:  ld_ext = {{16{req_sign & ld_pair[15]}}, ld_pair[15:0]};
            default: ld_ext = ld_pair[31:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lo_reg <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok && misaligned) begin
                        if (req_rd) begin
                            lo_reg <= Dcache_DataRd;
                            state  <= LD_HI;
                        end else begin
                            cnt   <= 2'd1;
                            state <= ST_BYTE;
                        end
                    end
                end
                LD_HI: state <= IDLE;
                ST_BYTE: begin
                    if (cnt == st_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_ok;

    assign in_idle   = 1'b1;
    assign unused_ok = &{1'b0, clk, rst};
`endif

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        align_stall     = 1'b0;
        align_ldata     = '0;
        align_misalign  = 1'b0;
        Mem_DcacheEN    = 1'b0;
        Mem_DcacheRd    = 1'b0;
        Mem_DcacheWidth = 2'b00;
        Mem_DcacheSign  = 1'b0;
        Mem_DcacheAddr  = '0;
        EXMem_Rs2Data   = '0;

        if (in_idle && req_ok && !misaligned) begin
            Mem_DcacheEN    = 1'b1;
            Mem_DcacheRd    = req_rd;
            Mem_DcacheWidth = req_width;
            Mem_DcacheSign  = req_sign;
            Mem_DcacheAddr  = req_addr;
            EXMem_Rs2Data   = req_wdata;
            align_ldata     = Dcache_DataRd;
        end

`ifdef MEM_ALIGN_SPLIT_EN
        case (state)
            IDLE: begin
                if (req_ok && misaligned) begin
                    Mem_DcacheEN = 1'b1;
                    align_stall  = 1'b1;
                    if (req_rd) begin
                        Mem_DcacheRd    = 1'b1;
                        Mem_DcacheWidth = W_WORD;
                        Mem_DcacheAddr  = base;
                    end else begin
                        Mem_DcacheWidth = W_BYTE;
                        Mem_DcacheAddr  = req_addr;
                        EXMem_Rs2Data   = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                    end
                end
            end
            LD_HI: begin
                Mem_DcacheEN    = 1'b1;
                Mem_DcacheRd    = 1'b1;
                Mem_DcacheWidth = W_WORD;
                Mem_DcacheAddr  = base + ADDR_W'(4);
                align_ldata     = ld_ext;
            end
            ST_BYTE: begin
                Mem_DcacheEN    = 1'b1;
                Mem_DcacheWidth = W_BYTE;
                Mem_DcacheAddr  = req_addr + ADDR_W'(cnt);
                EXMem_Rs2Data   = {{(DATA_W-8){1'b0}}, req_wdata[{cnt, 3'b000} +: 8]};
                align_stall     = (cnt != st_last);
            end
            default: ;
        endcase
`else
        if (req_ok && misaligned)
            align_misalign = 1'b1;
`endif
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit with a small behavioural data cache.
// Exercises the split path when MEM_ALIGN_SPLIT_EN is defined, the flagging path otherwise.
module tb_mem_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en, req_rd, req_sign;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        align_stall, align_misalign;
    logic [31:0] align_ldata;
    logic        Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheSign;
    logic [1:0]  Mem_DcacheWidth;
    logic [31:0] Mem_DcacheAddr, EXMem_Rs2Data, Dcache_DataRd;

    logic [31:0] mem [16];
    int vectors = 0;
    int miscompares = 0;

    mem_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_rd(req_rd), .req_width(req_width), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .align_stall(align_stall), .align_ldata(align_ldata), .align_misalign(align_misalign),
        .Mem_DcacheEN(Mem_DcacheEN), .Mem_DcacheRd(Mem_DcacheRd),
        .Mem_DcacheWidth(Mem_DcacheWidth), .Mem_DcacheSign(Mem_DcacheSign),
        .Mem_DcacheAddr(Mem_DcacheAddr), .EXMem_Rs2Data(EXMem_Rs2Data),
        .Dcache_DataRd(Dcache_DataRd)
    );

    always #5 clk = ~clk;

    // Cache read: word lookup, then byte/half extraction per width and sign.
    always_comb begin
        logic [31:0] word, sh;
        word = mem[Mem_DcacheAddr[5:2]];
        sh   = word >> {Mem_DcacheAddr[1:0], 3'b000};
        case (Mem_DcacheWidth)
            2'b00:   Dcache_DataRd = {{24{Mem_DcacheSign & sh[7]}}, sh[7:0]};
            2'b01:   Dcache_DataRd = {{16{Mem_DcacheSign & sh[15]}}, sh[15:0]};
            default: Dcache_DataRd = word;
        endcase
    end

    always @(posedge clk) begin
        if (Mem_DcacheEN && !Mem_DcacheRd) begin
            case (Mem_DcacheWidth)
                2'b00: mem[Mem_DcacheAddr[5:2]][{Mem_DcacheAddr[1:0], 3'b000} +: 8] <= EXMem_Rs2Data[7:0];
                2'b01: mem[Mem_DcacheAddr[5:2]][{Mem_DcacheAddr[1], 4'b0000} +: 16] <= EXMem_Rs2Data[15:0];
                default: mem[Mem_DcacheAddr[5:2]] <= EXMem_Rs2Data;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rd, input logic [1:0] w,
                         input logic sgn, input logic [31:0] a, input logic [31:0] d);
        req_en = en; req_rd = rd; req_width = w; req_sign = sgn; req_addr = a; req_wdata = d;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        mem[2] = 32'hCCBBAA99;
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", align_stall, 0);
        check("rst_ldata", align_ldata, 0);
        check("rst_misalign", align_misalign, 0);
        check("rst_en", Mem_DcacheEN, 0);
        check("rst_addr", Mem_DcacheAddr, 0);
        check("rst_wdata", EXMem_Rs2Data, 0);

        // Aligned word load passes straight through.
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h4, 0); #1;
        check("lw4_ldata", align_ldata, 32'h88776655);
        check("lw4_stall", align_stall, 0);
        check("lw4_addr", Mem_DcacheAddr, 32'h4);
        check("lw4_width", Mem_DcacheWidth, 2'b10);
        check("lw4_en", Mem_DcacheEN, 1);

        next_cycle(); drive(1, 1, 2'b11, 0, 32'h4, 0); #1;
        check("inv_en", Mem_DcacheEN, 0);
        check("inv_stall", align_stall, 0);

`ifdef MEM_ALIGN_SPLIT_EN
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h2, 0); #1;
        check("lw2_c0_stall", align_stall, 1);
        check("lw2_c0_addr", Mem_DcacheAddr, 32'h0);
        check("lw2_c0_width", Mem_DcacheWidth, 2'b10);
        next_cycle();
        check("lw2_c1_addr", Mem_DcacheAddr, 32'h4);
        check("lw2_c1_ldata", align_ldata, 32'h66554433);
        check("lw2_c1_stall", align_stall, 0);

        next_cycle(); drive(1, 1, 2'b01, 1, 32'h7, 0); #1;
        check("lh7_c0_stall", align_stall, 1);
        check("lh7_c0_addr", Mem_DcacheAddr, 32'h4);
        next_cycle();
        check("lh7_c1_addr", Mem_DcacheAddr, 32'h8);
        check("lh7_ldata", align_ldata, 32'hFFFF9988);
        check("lh7_c1_stall", align_stall, 0);

        next_cycle(); drive(1, 1, 2'b01, 0, 32'h7, 0); #1;
        check("lhu7_c0_stall", align_stall, 1);
        next_cycle();
        check("lhu7_ldata", align_ldata, 32'h00009988);
        check("lhu7_c1_stall", align_stall, 0);

        // Misaligned word store: four byte writes, stall 1,1,1,0.
        next_cycle(); drive(1, 0, 2'b10, 0, 32'h1, 32'hDEADBEEF); #1;
        check("sw1_c0_addr", Mem_DcacheAddr, 32'h1);
        check("sw1_c0_data", EXMem_Rs2Data, 32'hEF);
        check("sw1_c0_width", Mem_DcacheWidth, 2'b00);
        check("sw1_c0_rd", Mem_DcacheRd, 0);
        check("sw1_c0_stall", align_stall, 1);
        next_cycle();
        check("sw1_c1_addr", Mem_DcacheAddr, 32'h2);
        check("sw1_c1_data", EXMem_Rs2Data, 32'hBE);
        check("sw1_c1_stall", align_stall, 1);
        next_cycle();
        check("sw1_c2_addr", Mem_DcacheAddr, 32'h3);
        check("sw1_c2_data", EXMem_Rs2Data, 32'hAD);
        check("sw1_c2_stall", align_stall, 1);
        next_cycle();
        check("sw1_c3_addr", Mem_DcacheAddr, 32'h4);
        check("sw1_c3_data", EXMem_Rs2Data, 32'hDE);
        check("sw1_c3_stall", align_stall, 0);
        next_cycle(); drive(0, 0, 2'b00, 0, 32'h0, 0); #1;
        check("sw1_word0", mem[0], 32'hADBEEF11);
        check("sw1_word1", mem[1], 32'h887766DE);
        check("sw1_idle_en", Mem_DcacheEN, 0);

        // Misaligned halfword store: two byte writes, stall 1,0.
        next_cycle(); drive(1, 0, 2'b01, 0, 32'h3, 32'h00001234); #1;
        check("sh3_c0_addr", Mem_DcacheAddr, 32'h3);
        check("sh3_c0_data", EXMem_Rs2Data, 32'h34);
        check("sh3_c0_stall", align_stall, 1);
        next_cycle();
        check("sh3_c1_addr", Mem_DcacheAddr, 32'h4);
        check("sh3_c1_data", EXMem_Rs2Data, 32'h12);
        check("sh3_c1_stall", align_stall, 0);
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h0, 0); #1;
        check("sh3_word0", align_ldata, 32'h34BEEF11);
        check("sh3_word1", mem[1], 32'h88776612);

        // Address wraps past the top of the space into word 0.
        next_cycle(); drive(1, 1, 2'b10, 0, 32'hFFFFFFFE, 0); #1;
        check("wrap_c0_addr", Mem_DcacheAddr, 32'hFFFFFFFC);
        next_cycle();
        check("wrap_c1_addr", Mem_DcacheAddr, 32'h0);
        check("wrap_ldata", align_ldata, 32'hEF110000);

        // Reset during LD_HI returns to IDLE.
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h2, 0); #1;
        check("rsthi_c0_stall", align_stall, 1);
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; drive(0, 0, 2'b00, 0, 32'h0, 0); #1;
        check("rsthi_stall", align_stall, 0);
        check("rsthi_en", Mem_DcacheEN, 0);
        check("rsthi_ldata", align_ldata, 0);
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h8, 0); #1;
        check("rsthi_lw8", align_ldata, 32'hCCBBAA99);
        check("rsthi_lw8_stall", align_stall, 0);
`else
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h2, 0); #1;
        check("lw2_misalign", align_misalign, 1);
        check("lw2_en", Mem_DcacheEN, 0);
        check("lw2_stall", align_stall, 0);
        check("lw2_ldata", align_ldata, 0);

        next_cycle(); drive(1, 1, 2'b01, 1, 32'h7, 0); #1;
        check("lh7_misalign", align_misalign, 1);
        check("lh7_en", Mem_DcacheEN, 0);

        next_cycle(); drive(1, 0, 2'b10, 0, 32'h1, 32'hDEADBEEF); #1;
        check("sw1_misalign", align_misalign, 1);
        check("sw1_en", Mem_DcacheEN, 0);
        next_cycle(); drive(0, 0, 2'b00, 0, 32'h0, 0); #1;
        check("sw1_word0", mem[0], 32'h44332211);
        check("sw1_word1", mem[1], 32'h88776655);

        next_cycle(); drive(1, 1, 2'b10, 0, 32'h4, 0); #1;
        check("lw4b_ldata", align_ldata, 32'h88776655);
        check("lw4b_misalign", align_misalign, 0);

        next_cycle(); drive(1, 0, 2'b10, 0, 32'h8, 32'h01020304); #1;
        check("sw8_en", Mem_DcacheEN, 1);
        check("sw8_rd", Mem_DcacheRd, 0);
        check("sw8_addr", Mem_DcacheAddr, 32'h8);
        check("sw8_data", EXMem_Rs2Data, 32'h01020304);
        next_cycle(); drive(1, 1, 2'b10, 0, 32'h8, 0); #1;
        check("lw8_ldata", align_ldata, 32'h01020304);

        next_cycle(); drive(1, 1, 2'b00, 1, 32'h7, 0); #1;
        check("lb7_ldata", align_ldata, 32'hFFFFFF88);
        check("lb7_sign", Mem_DcacheSign, 1);
        next_cycle(); drive(1, 1, 2'b01, 0, 32'h6, 0); #1;
        check("lhu6_ldata", align_ldata, 32'h00008877);
        check("lhu6_misalign", align_misalign, 0);
`endif

        next_cycle(); drive(0, 0, 2'b00, 0, 32'h0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
